// File: rtl/ahb_nametable_dma_master.sv
// AHB-Lite single-beat copy engine: flash window -> nameTable RAM.
// Reads one word, writes it, repeats for word_cnt words.
module ahb_nametable_dma_master #(
  parameter int         CNT_WIDTH = 11,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic                 HWRITE,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic [1:0]           HRESP
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO = '0;

  logic [2:0]           state;
  logic [31:0]          src_ptr;
  logic [31:0]          dst_ptr;
  logic [CNT_WIDTH-1:0] remaining;
  logic [31:0]          data_reg;
  logic                 resp_err;
  logic                 unused_bits;

  assign HSIZE    = 3'b010;
  assign HBURST   = 3'b000;
  assign HPROT    = HPROT_VAL;
  assign HWDATA   = data_reg;
  assign resp_err = (HRESP == 2'b01);

  assign unused_bits = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HWRITE    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr   <= {src_addr[31:2], 2'b00};
            dst_ptr   <= {dst_addr[31:2], 2'b00};
            remaining <= word_cnt;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (word_cnt == ZERO) begin
              state <= S_FINISH;
            end else begin
              state  <= S_RD_ADDR;
              HADDR  <= {src_addr[31:2], 2'b00};
              HTRANS <= TR_NONSEQ;
              HWRITE <= 1'b0;
            end
          end
        end
        S_RD_ADDR: begin
          if (HREADY) begin
            state  <= S_RD_DATA;
            HTRANS <= TR_IDLE;
          end
        end
        S_RD_DATA: begin
          if (HREADY) begin
            if (resp_err) begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end else begin
              data_reg <= HRDATA;
              state    <= S_WR_ADDR;
              HADDR    <= dst_ptr;
              HTRANS   <= TR_NONSEQ;
              HWRITE   <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (HREADY) begin
            state  <= S_WR_DATA;
            HTRANS <= TR_IDLE;
          end
        end
        S_WR_DATA: begin
          if (HREADY) begin
            HWRITE <= 1'b0;
            if (resp_err) begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end else begin
              src_ptr   <= src_ptr + 32'd4;
              dst_ptr   <= dst_ptr + 32'd4;
              remaining <= remaining - ONE;
              if (remaining == ONE) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_FINISH;
              end else begin
                state  <= S_RD_ADDR;
                HADDR  <= src_ptr + 32'd4;
                HTRANS <= TR_NONSEQ;
              end
            end
          end
        end
        S_FINISH: begin
          // Zero-length copies arrive here still busy; pulse done now.
          done  <= busy;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_nametable_dma_master.sv
// Bench for ahb_nametable_dma_master: AHB slave model with wait/error
// injection and a word-copy reference model.
module tb_ahb_nametable_dma_master;

  localparam int CW = 11;
  localparam int LIMIT = 400;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          start;
  logic [31:0]   src_addr, dst_addr;
  logic [CW-1:0] word_cnt;
  logic          busy, done, error;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS, HRESP;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic          HWRITE, HREADY;

  int checks = 0;
  int failures = 0;

  ahb_nametable_dma_master #(.CNT_WIDTH(CW), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wq_a[$], wq_d[$], rd_q[$];
  logic [31:0] ea[$], ed[$];
  int          nonseq_cnt, stab_err;
  int          dwait;
  bit          aw_en, err_en;
  logic [31:0] err_addr;

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference: word i of the copy moves src+4i to dst+4i, stopping at a failed read.
  function automatic void build_exp(input logic [31:0] s, input logic [31:0] d,
                                    input int n, input int err_idx);
    ea.delete(); ed.delete();
    for (int i = 0; i < n; i++) begin
      if (i == err_idx) break;
      ea.push_back({d[31:2], 2'b00} + 32'(4 * i));
      ed.push_back(rdmem({s[31:2], 2'b00} + 32'(4 * i)));
    end
  endfunction

  // AHB slave + protocol monitor
  initial begin : slave
    int          dphase, d_wait;
    bit          d_err, stalled, dstall;
    logic [31:0] d_addr, p_addr, p_wdata;
    logic        p_wr;
    dphase = 0; d_wait = 0; d_err = 0; stalled = 0; dstall = 0;
    d_addr = 0; p_addr = 0; p_wdata = 0; p_wr = 0;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    forever begin
      @(posedge HCLK);
      if (!HRESETn) begin
        dphase = 0; stalled = 0; dstall = 0;
      end else begin
        if (stalled && (HADDR !== p_addr || HTRANS !== 2'b10 || HWRITE !== p_wr))
          stab_err++;
        if (dstall && HWDATA !== p_wdata) stab_err++;
        stalled = (HTRANS == 2'b10) && !HREADY;
        dstall  = (dphase == 2) && !HREADY;
        p_addr = HADDR; p_wr = HWRITE; p_wdata = HWDATA;
        if (dphase != 0 && HREADY) begin
          if (dphase == 2 && !d_err) begin
            mem[d_addr] = HWDATA;
            wq_a.push_back(d_addr);
            wq_d.push_back(HWDATA);
          end
          dphase = 0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          nonseq_cnt++;
          dphase = HWRITE ? 2 : 1;
          d_addr = HADDR;
          if (!HWRITE) rd_q.push_back(HADDR);
          d_err  = err_en && !HWRITE && (HADDR == err_addr);
          d_wait = dwait;
          if (d_err && d_wait == 0) d_wait = 1;
        end
      end
      #1;
      if (dphase != 0) begin
        if (d_wait > 0) begin
          HREADY = 1'b0;
          d_wait--;
          HRESP = (d_err && d_wait == 0) ? 2'b01 : 2'b00;
        end else begin
          HREADY = 1'b1;
          HRESP  = d_err ? 2'b01 : 2'b00;
          HRDATA = rdmem(d_addr);
        end
      end else begin
        HREADY = aw_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        HRESP  = 2'b00;
      end
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int restart_at, output int cyc, output int busy_cyc);
    wq_a.delete(); wq_d.delete(); rd_q.delete();
    nonseq_cnt = 0; stab_err = 0;
    @(negedge HCLK);
    src_addr = s; dst_addr = d; word_cnt = CW'(n); start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    cyc = 1; busy_cyc = 0;
    while (!done && cyc < LIMIT) begin
      if (busy) busy_cyc++;
      if (cyc == restart_at) begin
        src_addr = 32'h3000_0000; dst_addr = 32'h3100_0000;
        word_cnt = CW'(5); start = 1'b1;
      end else start = 1'b0;
      @(negedge HCLK);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout got=no_done after %0d cycles req=done", cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    checks++;
    if ({busy, done, error, HTRANS, HWRITE} !== 6'b0 || HADDR !== 0 || HWDATA !== 0) begin
      failures++;
      $display("FAIL reset_state got=b%b d%b e%b t%b w%b a%h wd%h req=all zero",
               busy, done, error, HTRANS, HWRITE, HADDR, HWDATA);
    end
    checks++;
    if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011) begin
      failures++;
      $display("FAIL fixed_ctrl got=%b/%b/%b req=010/000/0011", HSIZE, HBURST, HPROT);
    end
  endtask

  task automatic test_copy3();
    int cyc, bc;
    dwait = 0; aw_en = 0; err_en = 0;
    mem[32'h0010_0000] = 32'hA1;
    mem[32'h0010_0004] = 32'hB2;
    mem[32'h0010_0008] = 32'hC3;
    build_exp(32'h0010_0000, 32'h0, 3, -1);
    run_copy(32'h0010_0000, 32'h0, 3, 0, cyc, bc);
    checks++;
    if (cyc != 13) begin
      failures++; $display("FAIL copy3_latency got=%0d req=13", cyc);
    end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL copy3_flags got=busy%b err%b req=0 0", busy, error);
    end
    checks++;
    if (wq_a.size() != 3) begin
      failures++; $display("FAIL copy3_count got=%0d req=3", wq_a.size());
    end
    foreach (ea[i]) begin
      checks++;
      if (i >= wq_a.size() || wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
        failures++;
        $display("FAIL copy3_wr%0d got=%h:%h req=%h:%h", i, wq_a[i], wq_d[i], ea[i], ed[i]);
      end
    end
    @(negedge HCLK);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL copy3_done_width got=%b req=0", done);
    end
  endtask

  task automatic test_zero();
    int cyc, bc;
    dwait = 0; aw_en = 0; err_en = 0;
    run_copy(32'h0010_0000, 32'h2000_0000, 0, 0, cyc, bc);
    checks++;
    if (cyc != 2 || bc != 1) begin
      failures++; $display("FAIL zero_timing got=done@%0d busy%0d req=done@2 busy1", cyc, bc);
    end
    checks++;
    if (nonseq_cnt != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_nobus got=nonseq%0d busy%b req=0 0", nonseq_cnt, busy);
    end
  endtask

  task automatic test_waits();
    int cyc, bc, n;
    logic [31:0] s, d;
    n = $urandom_range(2, 6);
    s = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
    d = 32'h2000_0000 | ($urandom & 32'h0000_07FC);
    dwait = 2; aw_en = 1; err_en = 0;
    build_exp(s, d, n, -1);
    run_copy(s, d, n, 0, cyc, bc);
    checks++;
    if (wq_a.size() != n) begin
      failures++; $display("FAIL waits_count got=%0d req=%0d", wq_a.size(), n);
    end
    foreach (ea[i]) begin
      checks++;
      if (i >= wq_a.size() || wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
        failures++;
        $display("FAIL waits_wr%0d got=%h:%h req=%h:%h", i, wq_a[i], wq_d[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      failures++; $display("FAIL waits_stable got=%0d req=0", stab_err);
    end
    checks++;
    if (cyc < 8 * n + 1) begin
      failures++; $display("FAIL waits_latency got=%0d req>=%0d", cyc, 8 * n + 1);
    end
    dwait = 0; aw_en = 0;
  endtask

  task automatic test_error();
    int cyc, bc;
    logic [31:0] s;
    s = 32'h1100_0000 | ($urandom & 32'h000F_FFFC);
    dwait = 0; aw_en = 0; err_en = 1; err_addr = s + 32'd4;
    build_exp(s, 32'h2000_1000, 4, 1);
    run_copy(s, 32'h2000_1000, 4, 0, cyc, bc);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL err_flag got=err%b busy%b req=1 0", error, busy);
    end
    checks++;
    if (wq_a.size() != 1 || wq_a[0] !== ea[0] || wq_d[0] !== ed[0]) begin
      failures++; $display("FAIL err_writes got=%0d req=1 to %h", wq_a.size(), ea[0]);
    end
    checks++;
    if (nonseq_cnt != 3) begin
      failures++; $display("FAIL err_nonseq got=%0d req=3", nonseq_cnt);
    end
    repeat (3) @(negedge HCLK);
    checks++;
    if (error !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b req=1", error);
    end
    err_en = 0;
    run_copy(32'h1200_0000, 32'h2000_2000, 1, 0, cyc, bc);
    checks++;
    if (error !== 1'b0 || wq_a.size() != 1) begin
      failures++; $display("FAIL err_clear got=err%b wr%0d req=0 1", error, wq_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    dwait = 0; aw_en = 0; err_en = 0;
    build_exp(32'hFFFF_FFFE, 32'h2000_3000, 2, -1);
    run_copy(32'hFFFF_FFFE, 32'h2000_3000, 2, 3, cyc, bc);
    checks++;
    if (rd_q.size() != 2 || rd_q[0] !== 32'hFFFF_FFFC || rd_q[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_reads got=%0d %h %h req=2 fffffffc 00000000",
               rd_q.size(), rd_q[0], rd_q[1]);
    end
    foreach (ea[i]) begin
      checks++;
      if (i >= wq_a.size() || wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
        failures++;
        $display("FAIL wrap_wr%0d got=%h:%h req=%h:%h", i, wq_a[i], wq_d[i], ea[i], ed[i]);
      end
    end
    repeat (4) @(negedge HCLK);
    checks++;
    if (nonseq_cnt != 4 || busy !== 1'b0 || cyc != 9) begin
      failures++;
      $display("FAIL restart_ignored got=nonseq%0d busy%b done@%0d req=4 0 9",
               nonseq_cnt, busy, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bc, dones;
    dwait = 0; aw_en = 0; err_en = 0;
    wq_a.delete(); wq_d.delete();
    @(negedge HCLK);
    src_addr = 32'h1300_0000; dst_addr = 32'h2000_4000; word_cnt = CW'(3); start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || busy !== 1'b0 || error !== 1'b0 || HWRITE !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=t%b busy%b err%b w%b req=00 0 0 0", HTRANS, busy, error, HWRITE);
    end
    dones = 0;
    repeat (3) begin
      @(negedge HCLK);
      if (done) dones++;
    end
    HRESETn = 1'b1;
    repeat (4) begin
      @(negedge HCLK);
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || wq_a.size() != 0) begin
      failures++; $display("FAIL reset_no_done got=done%0d wr%0d req=0 0", dones, wq_a.size());
    end
    build_exp(32'h1300_0100, 32'h2000_5000, 3, -1);
    run_copy(32'h1300_0100, 32'h2000_5000, 3, 0, cyc, bc);
    checks++;
    if (cyc != 13 || wq_a.size() != 3 || wq_d[2] !== ed[2] || wq_a[2] !== ea[2]) begin
      failures++; $display("FAIL reset_recover got=@%0d wr%0d req=@13 wr3", cyc, wq_a.size());
    end
  endtask

  task automatic test_random();
    int cyc, bc, n;
    logic [31:0] s, d;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 8);
      s = 32'h1400_0000 | ($urandom & 32'h00FF_FFFF);
      d = 32'h2100_0000 | ($urandom & 32'h0000_07FF);
      dwait = $urandom_range(0, 2); aw_en = $urandom_range(0, 1); err_en = 0;
      build_exp(s, d, n, -1);
      run_copy(s, d, n, 0, cyc, bc);
      checks++;
      if (wq_a.size() != n || error !== 1'b0 || stab_err != 0) begin
        failures++;
        $display("FAIL rand%0d_summary got=wr%0d err%b stab%0d req=%0d 0 0",
                 k, wq_a.size(), error, stab_err, n);
      end
      foreach (ea[i]) begin
        checks++;
        if (i >= wq_a.size() || wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
          failures++;
          $display("FAIL rand%0d_wr%0d got=%h:%h req=%h:%h", k, i, wq_a[i], wq_d[i], ea[i], ed[i]);
        end
      end
      if (dwait == 0 && !aw_en) begin
        checks++;
        if (cyc != 4 * n + 1) begin
          failures++; $display("FAIL rand%0d_latency got=%0d req=%0d", k, cyc, 4 * n + 1);
        end
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0;
    src_addr = '0; dst_addr = '0; word_cnt = '0;
    dwait = 0; aw_en = 0; err_en = 0; err_addr = '0;
    nonseq_cnt = 0; stab_err = 0;
    repeat (3) @(negedge HCLK);
    test_reset();
    HRESETn = 1'b1;
    test_reset();
    test_copy3();
    test_zero();
    test_waits();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_nametable_dma_master.md
Name: ahb_nametable_dma_master

Overview:
- AHB-Lite master that copies level tile data word-by-word from a source address (flash window) into the nameTable RAM AHB window (nameTable slave offsets 0x000–0x7FF).
- Issued by the background/scroll logic when a new map strip must be loaded; it is the initiator that drives the nameTable slave's bus.
- Single-beat, non-overlapped transfers: read one word, then write it; repeat for the programmed count.

Parameters:
CNT_WIDTH, 11, width of the word-count input; max copy length is 2^CNT_WIDTH-1 words.
HPROT_VAL, 4'b0011, constant driven on HPROT (privileged data access).

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches a copy when idle
src_addr  input  32  source byte address; bits [1:0] ignored
dst_addr  input  32  destination byte address; bits [1:0] ignored
word_cnt  input  CNT_WIDTH  number of 32-bit words to copy
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse (also on abort)
error  output  1  sticky slave-error flag, cleared by next accepted start
HADDR  output  32  AHB address
HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
HSIZE  output  3  fixed 3'b010 (word)
HBURST  output  3  fixed 3'b000 (SINGLE)
HPROT  output  4  HPROT_VAL
HWRITE  output  1  transfer direction
HWDATA  output  32  write data
HRDATA  input  32  read data
HREADY  input  1  bus ready
HRESP  input  2  2'b00 OKAY, 2'b01 ERROR

Behaviour:
- Reset: state IDLE, busy=0, done=0, error=0, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, internal counters/pointers 0. Reset mid-copy aborts instantly; no done pulse.
- start sampled only in IDLE; start while busy ignored. On accept: src_ptr<={src_addr[31:2],2'b00}, dst_ptr likewise, remaining<=word_cnt, error<=0, busy<=1.
- word_cnt==0: state goes IDLE→FINISH, done pulses next cycle, no bus transfer.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH.
- RD_ADDR: HADDR=src_ptr, HTRANS=NONSEQ, HWRITE=0. Advance to RD_DATA when HREADY=1; otherwise hold all address-phase signals.
- RD_DATA: HTRANS=IDLE. When HREADY=1: if HRESP==OKAY capture HRDATA into data_reg, go WR_ADDR; if HRESP==ERROR set error, go FINISH.
- WR_ADDR: HADDR=dst_ptr, HTRANS=NONSEQ, HWRITE=1; advance to WR_DATA on HREADY=1.
- WR_DATA: HTRANS=IDLE, HWDATA=data_reg stable for whole data phase. On HREADY=1: ERROR → set error, FINISH; OKAY → src_ptr+=4, dst_ptr+=4, remaining-=1; if remaining was 1 → FINISH, else RD_ADDR.
- HRESP ERROR sampled with HREADY=0 (first cycle of the two-cycle response) is ignored; the decision is made on the HREADY=1 cycle.
- FINISH: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE. busy drops in the same cycle done is high.
- Pointers wrap modulo 2^32 with no error.
- Throughput with HREADY always 1: 4 cycles per word; copy of N words finishes with done asserted at cycle 4N+1 after the start cycle.
- Outputs are registered; HADDR/HWRITE/HTRANS change only on state transitions.

Test Plan:
- Copy 3 words, src=0x0010_0000, dst=0x0000_0000, HREADY=1, memory words 0xA1,0xB2,0xC3 → writes to 0x0,0x4,0x8 with those values; done at cycle 13; error=0.
- word_cnt=0 with start → no NONSEQ issued; done pulse 2 cycles after start; busy high for 1 cycle.
- Slave inserts 2 wait states on every data phase and 1 in an address phase → same data written; HADDR/HWDATA stable through waits; total cycles increase accordingly.
- Read of word 2 returns HRESP ERROR (two-cycle response) → no write of word 2; error=1; done pulses; next start clears error.
- start pulsed again while busy, and src_addr=0xFFFF_FFFC with 2 words → second start ignored; second read addresses 0x0000_0000 (wrap).
- HRESETn asserted in WR_DATA → HTRANS=IDLE, busy=0, error=0 immediately; no done pulse; a new start after release copies correctly.
